// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg
//   Shared constants for the IF -> ID fetch queue.
//   - FS_TO_DS_BUS_WD : width of the IF output packet
//   - FQ_DEPTH        : default queue depth (power of two, >= 2)
//   - FS_*_LSB / FS_*_BIT : field offsets inside the packet
//       bd[70] ex[69] excode[68:64] inst[63:32] pc[31:0]
package fetch_queue_pkg;

    localparam int FS_TO_DS_BUS_WD = 71;
    localparam int FQ_DEPTH        = 4;

    localparam int FS_PC_LSB       = 0;
    localparam int FS_INST_LSB     = 32;
    localparam int FS_EXCODE_LSB   = 64;
    localparam int FS_EX_BIT       = 69;
    localparam int FS_BD_BIT       = 70;

endpackage

// File: rtl/fetch_queue_regfile.sv
// fq_regfile
//   DEPTH x BUS_WD register array with one synchronous write port and one
//   asynchronous (combinational) read port. Every entry is cleared to zero
//   by the asynchronous reset.
//   Ports:
//     clk      - clock
//     reset    - asynchronous active-high reset
//     we       - write enable
//     wr_addr  - write index
//     wr_data  - write data
//     rd_addr  - read index
//     rd_data  - read data (combinational)
import fetch_queue_pkg::*;

module fq_regfile #(
    parameter int BUS_WD = FS_TO_DS_BUS_WD,
    parameter int DEPTH  = FQ_DEPTH,
    parameter int PTR_WD = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [PTR_WD-1:0] wr_addr,
    input  logic [BUS_WD-1:0] wr_data,
    input  logic [PTR_WD-1:0] rd_addr,
    output logic [BUS_WD-1:0] rd_data
);

    logic [BUS_WD-1:0] mem_reg [DEPTH];

    // One register per entry so each has its own decoded write enable.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    mem_reg[gi] <= '0;
                end else if (we && (wr_addr == PTR_WD'(gi))) begin
                    mem_reg[gi] <= wr_data;
                end
            end
        end
    endgenerate

    assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue
//   In-order instruction queue between IF and ID. Decouples instruction
//   SRAM latency from decode stalls. Packets are stored and forwarded
//   unmodified; flush (writeback exception/eret) discards everything queued.
//   Ports:
//     clk            - clock, rising edge
//     reset          - asynchronous active-high reset
//     fs_to_ds_valid - IF presents a packet
//     fs_to_ds_bus   - IF packet
//     fq_allowin     - queue accepts a packet this cycle (to IF)
//     ds_allowin     - ID accepts the head packet this cycle
//     fq_to_ds_valid - head packet valid
//     fq_to_ds_bus   - head packet (combinational read)
//     flush          - ws_ex | ws_eret
//     fq_count       - occupancy 0..DEPTH
import fetch_queue_pkg::*;

module fetch_queue #(
    parameter int BUS_WD = FS_TO_DS_BUS_WD,
    parameter int DEPTH  = FQ_DEPTH,
    parameter int PTR_WD = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fs_to_ds_valid,
    input  logic [BUS_WD-1:0] fs_to_ds_bus,
    output logic              fq_allowin,
    input  logic              ds_allowin,
    output logic              fq_to_ds_valid,
    output logic [BUS_WD-1:0] fq_to_ds_bus,
    input  logic              flush,
    output logic [PTR_WD:0]   fq_count
);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_WD:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_WD:0] rd_ptr_reg, rd_ptr_next;
    logic            empty;
    logic            full;
    logic            push;
    logic            pop;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[PTR_WD-1:0] == rd_ptr_reg[PTR_WD-1:0]) &&
                   (wr_ptr_reg[PTR_WD] != rd_ptr_reg[PTR_WD]);

    // Acceptance depends only on stored state and flush, never on ds_allowin,
    // so a full queue refuses a packet even in a cycle it pops. Held low while
    // reset is asserted so IF does not hand over a packet that would be lost.
    assign fq_allowin     = !full && !flush && !reset;
    assign fq_to_ds_valid = !empty && !flush;

    assign push = fs_to_ds_valid && fq_allowin;
    assign pop  = fq_to_ds_valid && ds_allowin;

    assign fq_count = wr_ptr_reg - rd_ptr_reg;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
        end
    end

    // Storage is not cleared on flush; the pointers alone define contents.
    fq_regfile #(
        .BUS_WD (BUS_WD),
        .DEPTH  (DEPTH),
        .PTR_WD (PTR_WD)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .we      (push),
        .wr_addr (wr_ptr_reg[PTR_WD-1:0]),
        .wr_data (fs_to_ds_bus),
        .rd_addr (rd_ptr_reg[PTR_WD-1:0]),
        .rd_data (fq_to_ds_bus)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: table-driven steps with hand-written expected
// count/valid/allowin, plus a queue-based scoreboard for packet contents.
module tb_fetch_queue;

    localparam int BW = 71;

    logic          clk = 1'b0;
    logic          reset;
    logic          fs_to_ds_valid;
    logic [BW-1:0] fs_to_ds_bus;
    logic          fq_allowin;
    logic          ds_allowin;
    logic          fq_to_ds_valid;
    logic [BW-1:0] fq_to_ds_bus;
    logic          flush;
    logic [2:0]    fq_count;

    fetch_queue dut (
        .clk            (clk),
        .reset          (reset),
        .fs_to_ds_valid (fs_to_ds_valid),
        .fs_to_ds_bus   (fs_to_ds_bus),
        .fq_allowin     (fq_allowin),
        .ds_allowin     (ds_allowin),
        .fq_to_ds_valid (fq_to_ds_valid),
        .fq_to_ds_bus   (fq_to_ds_bus),
        .flush          (flush),
        .fq_count       (fq_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [BW-1:0] sb [$];        // expected queue contents, head first
    logic [BW-1:0] last_pop;
    int            n_pops;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic        ds;
        logic        fl;
        int          exp_count;
        logic        exp_valid;
        logic        exp_allow;
    } vec_t;

    vec_t vecs [18];

    function automatic logic [BW-1:0] mk(input logic [31:0] pc);
        return {pc[2], pc[3], pc[8:4], ~pc, pc};
    endfunction

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare at negedge against the
    // scoreboard model, then update the model at the rising edge.
    task automatic step(input logic v, input logic [BW-1:0] b, input logic ds, input logic fl);
        logic e_valid, e_allow;
        fs_to_ds_valid = v;
        fs_to_ds_bus   = b;
        ds_allowin     = ds;
        flush          = fl;
        e_valid = (sb.size() > 0) && !fl;
        e_allow = (sb.size() < 4) && !fl;
        @(negedge clk);
        chk("count", BW'(fq_count), BW'(sb.size()));
        chk("valid", BW'(fq_to_ds_valid), BW'(e_valid));
        chk("allowin", BW'(fq_allowin), BW'(e_allow));
        if (e_valid) chk("head", fq_to_ds_bus, sb[0]);
        if (fl) begin
            sb.delete();
        end else begin
            if (e_valid && ds) begin
                last_pop = sb.pop_front();
                n_pops++;
            end
            if (v && e_allow) sb.push_back(b);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [BW-1:0] pt;
        logic [31:0]   exp_pc;

        reset = 1'b1;
        fs_to_ds_valid = 1'b0;
        fs_to_ds_bus = '0;
        ds_allowin = 1'b0;
        flush = 1'b0;
        n_pops = 0;
        last_pop = '0;

        // Fill 4, try a 5th, drain; then flush with 3 queued and a push.
        vecs[0]  = '{1, 32'hbfc00000, 0, 0, 0, 0, 1};
        vecs[1]  = '{1, 32'hbfc00004, 0, 0, 1, 1, 1};
        vecs[2]  = '{1, 32'hbfc00008, 0, 0, 2, 1, 1};
        vecs[3]  = '{1, 32'hbfc0000c, 0, 0, 3, 1, 1};
        vecs[4]  = '{1, 32'hbfc00010, 0, 0, 4, 1, 0};
        vecs[5]  = '{0, 32'h0,        1, 0, 4, 1, 0};
        vecs[6]  = '{0, 32'h0,        1, 0, 3, 1, 1};
        vecs[7]  = '{0, 32'h0,        1, 0, 2, 1, 1};
        vecs[8]  = '{0, 32'h0,        1, 0, 1, 1, 1};
        vecs[9]  = '{0, 32'h0,        1, 0, 0, 0, 1};
        vecs[10] = '{1, 32'h80000000, 0, 0, 0, 0, 1};
        vecs[11] = '{1, 32'h80000004, 0, 0, 1, 1, 1};
        vecs[12] = '{1, 32'h80000008, 0, 0, 2, 1, 1};
        vecs[13] = '{1, 32'h80000010, 0, 1, 3, 0, 0};
        vecs[14] = '{0, 32'h0,        1, 0, 0, 0, 1};
        vecs[15] = '{1, 32'h80000020, 0, 0, 0, 0, 1};
        vecs[16] = '{0, 32'h0,        1, 0, 1, 1, 1};
        vecs[17] = '{0, 32'h0,        1, 0, 0, 0, 1};

        // Reset state while reset is held.
        #2;
        chk("rst_valid", BW'(fq_to_ds_valid), BW'(0));
        chk("rst_count", BW'(fq_count), BW'(0));
        chk("rst_bus", fq_to_ds_bus, '0);
        chk("rst_allowin", BW'(fq_allowin), BW'(0));
        #6 reset = 1'b0;
        #1;
        chk("rel_allowin", BW'(fq_allowin), BW'(1));
        @(posedge clk);
        #1;

        // Table-driven sequence, hand expectations plus scoreboard.
        foreach (vecs[i]) begin
            @(negedge clk);
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 18; i++) begin
            fs_to_ds_valid = vecs[i].v;
            fs_to_ds_bus   = mk(vecs[i].pc);
            ds_allowin     = vecs[i].ds;
            flush          = vecs[i].fl;
            #1;
            chk($sformatf("vec%0d_count", i), BW'(fq_count), BW'(vecs[i].exp_count));
            chk($sformatf("vec%0d_valid", i), BW'(fq_to_ds_valid), BW'(vecs[i].exp_valid));
            chk($sformatf("vec%0d_allowin", i), BW'(fq_allowin), BW'(vecs[i].exp_allow));
            $display("[TB] vec %0d pc=%h ds=%0d fl=%0d count=%0d valid=%0d", i, vecs[i].pc,
                     vecs[i].ds, vecs[i].fl, fq_count, fq_to_ds_valid);
            step(vecs[i].v, mk(vecs[i].pc), vecs[i].ds, vecs[i].fl);
        end
        chk("drain_last", last_pop, mk(32'h80000020));

        // Stream 10 packets with ID always ready; order across the wrap.
        n_pops = 0;
        exp_pc = 32'hbfc00100;
        for (int i = 0; i < 12; i++) begin
            step(i < 10, mk(32'hbfc00100 + 32'(i * 4)), 1'b1, 1'b0);
            if (i >= 1 && i <= 10) begin
                chk($sformatf("stream_pop%0d", i), last_pop, mk(exp_pc));
                exp_pc += 32'd4;
            end
            if (i >= 1 && i <= 9) chk("stream_count", BW'(fq_count), BW'(1));
            $display("[TB] stream %0d count=%0d pops=%0d", i, fq_count, n_pops);
        end
        chk("stream_pops", BW'(n_pops), BW'(10));

        // Field passthrough.
        pt = {1'b1, 1'b1, 5'h04, 32'h00000000, 32'hbfc00001};
        step(1'b1, pt, 1'b0, 1'b0);
        #1;
        chk("passthru", fq_to_ds_bus, pt);
        $display("[TB] passthru bus=%h", fq_to_ds_bus);

        // Asynchronous reset mid-cycle with entries queued.
        step(1'b1, mk(32'hbfc00200), 1'b0, 1'b0);
        fs_to_ds_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("amid_valid", BW'(fq_to_ds_valid), BW'(0));
        chk("amid_count", BW'(fq_count), BW'(0));
        chk("amid_bus", fq_to_ds_bus, '0);
        #1 reset = 1'b0;
        #1;
        chk("amid_allowin", BW'(fq_allowin), BW'(1));
        $display("[TB] async reset count=%0d valid=%0d", fq_count, fq_to_ds_valid);
        sb.delete();
        @(posedge clk);
        #1;
        step(1'b0, '0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Small instruction queue between the IF stage and the ID stage.
- Accepts IF output packets `{bd, ex, excode, inst, pc}` and presents them to ID in order.
- Decouples instruction SRAM fetch latency from decode stalls.
- Flushed when writeback raises an exception or eret, discarding all queued packets.

Parameters:
- BUS_WD, 71, packet width; equals `FS_TO_DS_BUS_WD`. Layout: bd[70], ex[69], excode[68:64], inst[63:32], pc[31:0].
- DEPTH, 4, number of entries; must be a power of two, minimum 2.
- PTR_WD, 2, log2(DEPTH).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- fs_to_ds_valid  input  1  IF presents a packet.
- fs_to_ds_bus  input  BUS_WD  IF packet.
- fq_allowin  output  1  queue accepts a packet this cycle; wired to the IF stage's `ds_allowin`.
- ds_allowin  input  1  ID accepts the head packet this cycle.
- fq_to_ds_valid  output  1  head packet valid.
- fq_to_ds_bus  output  BUS_WD  head packet.
- flush  input  1  `ws_ex | ws_eret` from writeback.
- fq_count  output  PTR_WD+1  current occupancy, 0..DEPTH.

Behaviour:
- Storage: DEPTH x BUS_WD register array.
  - `wr_ptr` and `rd_ptr` are each PTR_WD+1 bits; the MSB is the wrap bit.
  - empty = (wr_ptr == rd_ptr).
  - full = (low bits equal) && (MSBs differ).
- `fq_count` = wr_ptr - rd_ptr, modulo 2^(PTR_WD+1).
- `fq_allowin` = !full && !flush.
  - Purely registered-state plus flush; no combinational path from `ds_allowin`.
  - A full queue does not accept in the same cycle it pops.
- push = fs_to_ds_valid && fq_allowin.
  - Writes `fs_to_ds_bus` to mem[wr_ptr low bits].
  - wr_ptr increments at the edge.
- `fq_to_ds_valid` = !empty && !flush.
- `fq_to_ds_bus` = mem[rd_ptr low bits]; combinational read of the head.
- pop = fq_to_ds_valid && ds_allowin; rd_ptr increments at the edge.
- Latency: a packet pushed at edge N is visible as head at cycle N+1 at the earliest. There is no bypass.
- Simultaneous push and pop in a non-full, non-empty queue: both pointers advance; count unchanged.
- Push into an empty queue while `ds_allowin` = 1: the packet is not consumed that cycle; it appears next cycle.
- Wrap-around: pointer low bits wrap DEPTH-1 -> 0; the MSB toggles; order is preserved across the wrap.
- Flush, on the edge where flush = 1:
  - wr_ptr and rd_ptr are cleared to 0.
  - Any push or pop requested in the same cycle is suppressed; both are already gated by !flush.
  - The queue is empty the next cycle.
  - Memory contents are not cleared.
- Reset, asynchronous:
  - wr_ptr = rd_ptr = 0; all memory entries = 0.
  - Resulting outputs: fq_to_ds_valid = 0, fq_to_ds_bus = 0, fq_allowin = 1 once reset deasserts (0 while reset = 1), fq_count = 0.
  - Reset mid-operation discards all entries immediately, without waiting for the clock.
- Packet fields, including ex/excode/bd, are passed through unmodified. The queue does not interpret them.
- No overflow or underflow is possible: push is gated by full, pop is gated by empty.

Decomposition:
- `mycpu.h` holds `FS_TO_DS_BUS_WD` (71) and `FQ_DEPTH` (4). The block uses `FS_TO_DS_BUS_WD` as the BUS_WD default.
- Field-offset defines go in `mycpu.h`: `FS_PC_LSB` 0, `FS_INST_LSB` 32, `FS_EXCODE_LSB` 64, `FS_EX_BIT` 69, `FS_BD_BIT` 70.
- One natural sub-module: `fq_regfile`, a DEPTH x BUS_WD array with one write port and one asynchronous read port, asynchronous reset to zero.
- Pointer, flag and handshake logic stay in `fetch_queue`.

Test Plan:
- Reset then idle: assert reset asynchronously mid-cycle -> fq_to_ds_valid = 0, fq_count = 0, fq_to_ds_bus = 0 immediately; fq_allowin = 1 after deassert.
- Fill with ds_allowin = 0: push pc = 0xbfc00000, 0xbfc00004, 0xbfc00008, 0xbfc0000c -> fq_count = 4, fq_allowin = 0; a 5th packet is held by IF and not written.
- Drain in order: raise ds_allowin -> fq_to_ds_bus[31:0] is 0xbfc00000, then 0xbfc00004, ...0xbfc0000c on successive cycles; then valid = 0, count = 0.
- Wrap and concurrent push/pop: stream 10 packets with ds_allowin = 1 continuously -> steady count = 1, no loss or duplication, pcs in order across the pointer wrap.
- Flush: with 3 entries queued, assert flush for 1 cycle together with fs_to_ds_valid = 1 (pc = 0x80000010) -> fq_to_ds_valid = 0 during flush; count = 0 next cycle; 0x80000010 is not stored.
- Field passthrough: push bd = 1, ex = 1, excode = 0x04, inst = 0x00000000, pc = 0xbfc00001 -> output bus bit-identical: 71'h{1,1,04,00000000,bfc00001}.
